// File: rtl/wam_pkg.sv
// Shared constants, key indexing and inject FSM encoding for the WAM 3x3 keypad.
package wam_pkg;

    localparam int NUM_KEYS = 9;
    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic {
        IDLE   = 1'b0,
        INJECT = 1'b1
    } inj_state_t;

    function automatic logic [3:0] key_index(input int c, input int r);
        return 4'(3 * c + r);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One button: 2-FF synchronizer, then a stable state that only flips after
// DEBOUNCE_MAX+1 consecutive cycles of disagreement.
module key_debouncer #(
    parameter int DB_W = 20,
    parameter logic [DB_W-1:0] DEBOUNCE_MAX = 20'd999_999
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic stable
);

    localparam logic [DB_W-1:0] CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};

    logic meta_r;
    logic sync_r;
    logic [DB_W-1:0] cnt_r;

    // Synchronizer, disagreement counter and stable state
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            cnt_r  <= {DB_W{1'b0}};
            stable <= 1'b0;
        end else begin
            meta_r <= button;
            sync_r <= meta_r;
            if (sync_r != stable) begin
                if (cnt_r == DEBOUNCE_MAX) begin
                    stable <= sync_r;
                    cnt_r  <= {DB_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= {DB_W{1'b0}};
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_responder.sv
// Key-matrix side of the WAM keypad: debounced buttons plus injected presses,
// answered on the row lines for whichever column the scanner drives.
module keypad_matrix_responder
    import wam_pkg::*;
#(
    parameter int DB_W = 20,
    parameter logic [DB_W-1:0] DEBOUNCE_MAX = 20'd999_999,
    parameter int INJ_W = 28,
    parameter logic [INJ_W-1:0] INJECT_CYCLES = 28'd24_999_999,
    parameter bit STRICT_ONEHOT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] buttons,
    input  logic [NUM_COLS-1:0] column,
    output logic [NUM_ROWS-1:0] row,
    input  logic                inject_req,
    input  logic [3:0]          inject_key,
    output logic                inject_ack,
    output logic                inject_err,
    output logic                busy,
    output logic [NUM_KEYS-1:0] press_strobe,
    output logic                press_valid,
    output logic [3:0]          press_key
);

    localparam logic [INJ_W-1:0] ICNT_ONE = {{(INJ_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_KEYS-1:0] KEY_ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    logic [NUM_KEYS-1:0] stable_s;
    logic [NUM_KEYS-1:0] eff_s;
    logic [NUM_KEYS-1:0] eff_q_r;
    logic [NUM_KEYS-1:0] forced_r;
    logic [NUM_KEYS-1:0] forced_s;
    logic [NUM_KEYS-1:0] strobe_s;
    logic [NUM_ROWS-1:0] row_s;
    logic [3:0]          key_s;
    logic [INJ_W-1:0]    icnt_r;
    logic [INJ_W-1:0]    icnt_s;
    logic                ack_s;
    logic                err_s;
    inj_state_t          state_r;
    inj_state_t          state_s;

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_db
            key_debouncer #(
                .DB_W(DB_W),
                .DEBOUNCE_MAX(DEBOUNCE_MAX)
            ) u_db (
                .clk(clk),
                .reset(reset),
                .button(buttons[k]),
                .stable(stable_s[k])
            );
        end
    endgenerate

    assign eff_s    = stable_s | forced_r;
    assign strobe_s = eff_s & ~eff_q_r;
    assign busy     = (state_r == INJECT);

    // Row response: a passive matrix, optionally silenced for multi-column drive
    always_comb begin
        row_s = {NUM_ROWS{1'b0}};
        if (!STRICT_ONEHOT || $onehot(column)) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    row_s[r] = row_s[r] | (column[c] & eff_s[key_index(c, r)]);
                end
            end
        end else begin
            row_s = {NUM_ROWS{1'b0}};
        end
    end

    // Lowest strobing key wins; scanned high to low so the last hit is the lowest
    always_comb begin
        key_s = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (strobe_s[i]) begin
                key_s = 4'(i);
            end else begin
                key_s = key_s;
            end
        end
    end

    // Inject FSM next-state and pulse outputs
    always_comb begin
        state_s  = state_r;
        icnt_s   = icnt_r;
        forced_s = forced_r;
        ack_s    = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (inject_req && (inject_key <= 4'd8)) begin
                    state_s  = INJECT;
                    forced_s = KEY_ONE << inject_key;
                    icnt_s   = INJECT_CYCLES;
                    ack_s    = 1'b1;
                end else if (inject_req) begin
                    err_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            INJECT: begin
                if (icnt_r != {INJ_W{1'b0}}) begin
                    icnt_s = icnt_r - ICNT_ONE;
                end else begin
                    forced_s = {NUM_KEYS{1'b0}};
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s  = IDLE;
                forced_s = {NUM_KEYS{1'b0}};
                icnt_s   = {INJ_W{1'b0}};
            end
        endcase
    end

    // State, edge-detect history and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            icnt_r       <= {INJ_W{1'b0}};
            forced_r     <= {NUM_KEYS{1'b0}};
            eff_q_r      <= {NUM_KEYS{1'b0}};
            row          <= {NUM_ROWS{1'b0}};
            inject_ack   <= 1'b0;
            inject_err   <= 1'b0;
            press_strobe <= {NUM_KEYS{1'b0}};
            press_valid  <= 1'b0;
            press_key    <= KEY_NONE;
        end else begin
            state_r      <= state_s;
            icnt_r       <= icnt_s;
            forced_r     <= forced_s;
            eff_q_r      <= eff_s;
            row          <= row_s;
            inject_ack   <= ack_s;
            inject_err   <= err_s;
            press_strobe <= strobe_s;
            press_valid  <= |strobe_s;
            press_key    <= key_s;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed bench for keypad_matrix_responder with short debounce/inject timings.
module tb_keypad_matrix_responder;

    localparam logic [19:0] DBM = 20'd3;
    localparam logic [27:0] INJ = 28'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] buttons;
    logic [2:0] column;
    logic       inject_req;
    logic [3:0] inject_key;

    logic [2:0] row, row_or;
    logic       inject_ack, inject_err, busy;
    logic       ack_or, err_or, busy_or;
    logic [8:0] press_strobe, strobe_or;
    logic       press_valid, valid_or;
    logic [3:0] press_key, key_or;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    keypad_matrix_responder #(
        .DB_W(20), .DEBOUNCE_MAX(DBM), .INJ_W(28), .INJECT_CYCLES(INJ), .STRICT_ONEHOT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .buttons(buttons), .column(column), .row(row),
        .inject_req(inject_req), .inject_key(inject_key), .inject_ack(inject_ack),
        .inject_err(inject_err), .busy(busy), .press_strobe(press_strobe),
        .press_valid(press_valid), .press_key(press_key)
    );

    keypad_matrix_responder #(
        .DB_W(20), .DEBOUNCE_MAX(DBM), .INJ_W(28), .INJECT_CYCLES(INJ), .STRICT_ONEHOT(1'b0)
    ) dut_or (
        .clk(clk), .reset(reset), .buttons(buttons), .column(column), .row(row_or),
        .inject_req(inject_req), .inject_key(inject_key), .inject_ack(ack_or),
        .inject_err(err_or), .busy(busy_or), .press_strobe(strobe_or),
        .press_valid(valid_or), .press_key(key_or)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lat, cnt_a, cnt_b, cnt_c, cnt_d, first_busy, first_row;
    bit found;

    initial begin
        reset = 1'b1; buttons = 9'd0; column = 3'd0; inject_req = 1'b0; inject_key = 4'd0;
        repeat (3) tick();
        chk_eq("rst_row", 32'(row), 32'd0);
        chk_eq("rst_ack", 32'(inject_ack), 32'd0);
        chk_eq("rst_err", 32'(inject_err), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_strobe", 32'(press_strobe), 32'd0);
        chk_eq("rst_valid", 32'(press_valid), 32'd0);
        chk_eq("rst_key", 32'(press_key), 32'hF);
        reset = 1'b0;
        tick();

        // clean press of key 4: 2 sync + 4 debounce + 1 strobe register
        buttons[4] = 1'b1;
        lat = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            lat++;
            if (press_strobe[4]) found = 1'b1;
        end
        chk_eq("t1_strobe_lat", 32'(lat), 32'd7);
        chk_eq("t1_strobe_vec", 32'(press_strobe), 32'h010);
        chk_eq("t1_press_key", 32'(press_key), 32'd4);
        chk_eq("t1_press_valid", 32'(press_valid), 32'd1);
        column = 3'b010;
        tick();
        chk_eq("t1_row", 32'(row), 32'b010);
        chk_eq("t1_strobe_once", 32'(press_strobe), 32'd0);
        chk_eq("t1_key_none", 32'(press_key), 32'hF);
        column = 3'b001;
        tick();
        chk_eq("t1_row_othercol", 32'(row), 32'd0);
        buttons[4] = 1'b0;
        cnt_a = 0;
        repeat (8) begin
            tick();
            if (press_valid) cnt_a++;
        end
        chk_eq("t1_release_nostrobe", 32'(cnt_a), 32'd0);

        // bouncing key 0 never debounces
        column = 3'b001;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 28; i++) begin
            if (i < 20 && (i % 2) == 0) buttons[0] = ~buttons[0];
            if (i == 20) buttons[0] = 1'b0;
            tick();
            if (press_strobe[0]) cnt_a++;
            if (row != 3'd0) cnt_b++;
        end
        chk_eq("t2_bounce_strobes", 32'(cnt_a), 32'd0);
        chk_eq("t2_bounce_row", 32'(cnt_b), 32'd0);

        // keys 0 and 3 (both row 0) with two columns driven
        buttons = 9'b000001001;
        repeat (8) tick();
        column = 3'b011;
        tick();
        chk_eq("t3_strict_row", 32'(row), 32'd0);
        chk_eq("t3_wiredor_row", 32'(row_or), 32'b001);
        column = 3'b001;
        tick();
        chk_eq("t3_onehot_row", 32'(row), 32'b001);
        column = 3'b000;
        tick();
        chk_eq("t3_nocol_row", 32'(row_or), 32'd0);
        buttons = 9'd0;
        repeat (8) tick();

        // injected press of key 8 on column 2
        column = 3'b100; inject_key = 4'd8; inject_req = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; first_busy = -1; first_row = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) inject_req = 1'b0;
            if (inject_ack) cnt_a++;
            if (busy) cnt_b++;
            if (row[2]) cnt_c++;
            if (press_strobe[8]) cnt_d++;
            if (busy && first_busy < 0) first_busy = i;
            if (row[2] && first_row < 0) first_row = i;
        end
        chk_eq("t4_ack_count", 32'(cnt_a), 32'd1);
        chk_eq("t4_busy_cycles", 32'(cnt_b), 32'd6);
        chk_eq("t4_row2_cycles", 32'(cnt_c), 32'd6);
        chk_eq("t4_strobe8_count", 32'(cnt_d), 32'd1);
        chk_eq("t4_row_delay", 32'(first_row - first_busy), 32'd1);
        chk_eq("t4_busy_first", 32'(first_busy), 32'd0);

        // bad key, then a request while already injecting
        inject_key = 4'd9; inject_req = 1'b1;
        tick();
        chk_eq("t5_err", 32'(inject_err), 32'd1);
        chk_eq("t5_err_noack", 32'(inject_ack), 32'd0);
        chk_eq("t5_err_nobusy", 32'(busy), 32'd0);
        inject_req = 1'b0;
        tick();
        chk_eq("t5_err_pulse", 32'(inject_err), 32'd0);
        column = 3'b000; inject_key = 4'd0; inject_req = 1'b1;
        tick();
        chk_eq("t5_ack", 32'(inject_ack), 32'd1);
        inject_key = 4'd1;
        cnt_a = 0;
        repeat (4) begin
            tick();
            if (inject_ack || inject_err) cnt_a++;
        end
        chk_eq("t5_busy_ignored", 32'(cnt_a), 32'd0);
        inject_req = 1'b0;
        repeat (4) tick();
        chk_eq("t5_back_idle", 32'(busy), 32'd0);

        // reset in the middle of an injection with key 2 held
        buttons[2] = 1'b1; column = 3'b001;
        repeat (9) tick();
        chk_eq("t6_row_held", 32'(row), 32'b100);
        inject_key = 4'd5; inject_req = 1'b1;
        tick();
        inject_req = 1'b0;
        chk_eq("t6_busy_pre", 32'(busy), 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_eq("t6_rst_busy", 32'(busy), 32'd0);
        chk_eq("t6_rst_row", 32'(row), 32'd0);
        chk_eq("t6_rst_key", 32'(press_key), 32'hF);
        reset = 1'b0;
        lat = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            lat++;
            if (press_strobe[2]) found = 1'b1;
        end
        chk_eq("t6_restrobe_lat", 32'(lat), 32'd7);
        chk_eq("t6_restrobe_key", 32'(press_key), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
